uart8_receiver: RTL and testbench

8-bit UART receiver. It recovers bytes from the serial line that the UART transmitter drives: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It sits downstream of the transmitter's `out` line (or the external RX pin) and presents each received byte in parallel with a one-cycle `done` pulse. The line is sampled with an oversampling clock, and each bit is taken at its midpoint.

---
 rtl/uart8_receiver.sv | 164 ++++++++++++++++
 tb/tb_uart8_receiver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart8_receiver.sv
// Purpose : 8N1 UART receiver, mid-bit sampling on an OVERSAMPLE clock, two-flop input synchronizer.
// Latency : out/err/done registered 2+OVERSAMPLE/2+9*OVERSAMPLE clk edges after the start edge is first captured.
// Backpr. : none; each byte is presented with a one-cycle done pulse and out holds until the next one.
module uart8_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in,
  output logic [7:0] out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4,
    S_BREAK = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    out_q, out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rx_s;

  // The FSM only ever looks at the second synchronizer stage.
  assign rx_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous line; idles at mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], in};
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      tick_q    <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: start validation at mid start bit, data/stop sampled a full bit later each.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    out_d     = out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;  // done is a single-cycle pulse, only STOP raises it
    err_d     = err_q;

    case (state_q)
      S_RESET: begin
        tick_d    = '0;
        bit_idx_d = '0;
        busy_d    = 1'b0;
        err_d     = 1'b0;
        if (en) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!rx_s) begin
          tick_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick_q == HALF_M1) begin
          if (!rx_s) begin
            busy_d    = 1'b1;
            tick_d    = '0;
            bit_idx_d = '0;
            state_d   = S_DATA;
          end else begin
            // Line came back high before mid start bit: a glitch, not a frame.
            state_d = S_IDLE;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_DATA: begin
        if (tick_q == FULL_M1) begin
          data_d    = {rx_s, data_q[7:1]};
          tick_d    = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_STOP: begin
        if (tick_q == FULL_M1) begin
          tick_d  = '0;
          out_d   = data_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = ~rx_s;
          // Leaving at mid stop bit lets a back-to-back start edge be caught.
          state_d = rx_s ? S_IDLE : S_BREAK;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_BREAK: begin
        // A line held low must return to mark before a new start is accepted.
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase

    // Disable wins over everything: drop the frame in progress without a done.
    if (!en) begin
      state_d   = S_RESET;
      tick_d    = '0;
      bit_idx_d = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_uart8_receiver.sv
// Bench for uart8_receiver at OVERSAMPLE=16: directed and random 8N1 frames.
// Expected bytes, error flags and done times come from a frame-level model of the line.
// Line changes on falling clock edges; DUT outputs sampled on falling edges.
module tb_uart8_receiver;

  localparam int OS = 16;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in;
  logic [7:0] out;
  logic       busy;
  logic       done;
  logic       err;

  uart8_receiver #(.OVERSAMPLE(OS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .in   (in),
    .out  (out),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  typedef struct {
    logic [7:0] b;
    logic       e;
    int         t;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = -1;
  int last_fall = -1;
  int rise_cnt = 0;
  logic busy_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge number: value of cyc after each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every done pulse and busy transition as seen between edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) got_q.push_back('{b: out, e: err, t: cyc});
      if (busy && !busy_prev) begin
        last_rise <= cyc;
        rise_cnt  <= rise_cnt + 1;
      end
      if (!busy && busy_prev) last_fall <= cyc;
    end
    busy_prev <= busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 frame whose bit period is num/den clk cycles; call on a falling edge.
  // e0 is the rising edge that first captures the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int num, input int den,
                            output int e0);
    logic [9:0] bits;
    int t;
    bits = {stop, b, 1'b0};
    e0 = cyc + 1;
    t = 0;
    for (int i = 0; i < 10; i++) begin
      in = bits[i];
      while (t < ((i + 1) * num) / den) begin
        @(negedge clk);
        t++;
      end
    end
  endtask

  // Frame-level model: a complete frame yields its data byte, err = stop bit low,
  // reported 2 + OS/2 + 9*OS edges after the start edge is captured.
  task automatic expect_frame(input logic [7:0] b, input logic stop, input int e0);
    exp_q.push_back('{b: b, e: ~stop, t: e0 + 2 + OS / 2 + 9 * OS});
  endtask

  task automatic check_frames(input string tag);
    int n;
    chk({tag, "_done_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_out"}, got_q[i].b, exp_q[i].b);
      chk({tag, "_err"}, got_q[i].e, exp_q[i].e);
      chk({tag, "_done_cycle"}, got_q[i].t, exp_q[i].t);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int e0, e1, rc, gap, num;
    logic [7:0] rb;

    rst_n = 1'b0;
    en    = 1'b1;
    in    = 1'b1;
    #1;
    chk("reset_out", out, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_err", err, 1'b0);
    idle(3);
    rst_n = 1'b1;
    idle(4);

    // Single frame with busy window.
    send_frame(8'hA5, 1'b1, OS, 1, e0);
    expect_frame(8'hA5, 1'b1, e0);
    in = 1'b1;
    idle(20);
    check_frames("single");
    chk("single_busy_rise", last_rise, e0 + 2 + OS / 2);
    chk("single_busy_fall", last_fall, e0 + 2 + OS / 2 + 9 * OS);

    // Back-to-back frames, one stop bit between them.
    send_frame(8'h00, 1'b1, OS, 1, e0);
    expect_frame(8'h00, 1'b1, e0);
    send_frame(8'hFF, 1'b1, OS, 1, e1);
    expect_frame(8'hFF, 1'b1, e1);
    in = 1'b1;
    idle(20);
    check_frames("b2b");

    // Glitch shorter than half a bit.
    rc = rise_cnt;
    in = 1'b0;
    idle(5);
    in = 1'b1;
    idle(40);
    chk("glitch_busy_rises", rise_cnt, rc);
    check_frames("glitch");

    // Framing error followed by a long break, then a clean frame.
    send_frame(8'h55, 1'b0, OS, 1, e0);
    expect_frame(8'h55, 1'b0, e0);
    idle(30 * OS);
    chk("break_err_held", err, 1'b1);
    in = 1'b1;
    idle(2 * OS);
    send_frame(8'h3C, 1'b1, OS, 1, e0);
    expect_frame(8'h3C, 1'b1, e0);
    in = 1'b1;
    idle(20);
    check_frames("break");

    // Random bytes, random gaps, tx bit period 15.5/16/16.5 clk.
    for (int k = 0; k < 6; k++) begin
      rb  = 8'($urandom);
      gap = $urandom_range(0, 40);
      num = $urandom_range(31, 33);
      send_frame(rb, 1'b1, num, 2, e0);
      expect_frame(rb, 1'b1, e0);
      in = 1'b1;
      idle(gap);
    end
    idle(20);
    check_frames("random");

    // Disable during data bit 4; the frame is dropped.
    fork
      send_frame(8'h96, 1'b1, OS, 1, e0);
      begin
        idle(88);
        chk("en_busy_before", busy, 1'b1);
        en = 1'b0;
        idle(1);
        chk("en_busy_after", busy, 1'b0);
        chk("en_done_after", done, 1'b0);
      end
    join
    in = 1'b1;
    idle(5);
    en = 1'b1;
    idle(4);
    check_frames("en_drop");
    send_frame(8'hC3, 1'b1, 33, 2, e0);
    expect_frame(8'hC3, 1'b1, e0);
    in = 1'b1;
    idle(20);
    check_frames("skew");

    // Asynchronous reset in mid-frame clears outputs at once.
    fork
      send_frame(8'h81, 1'b1, OS, 1, e0);
      begin
        idle(70);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", out, 8'h00);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_err", err, 1'b0);
      end
    join
    in = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(4);
    send_frame(8'h5A, 1'b1, OS, 1, e0);
    expect_frame(8'h5A, 1'b1, e0);
    in = 1'b1;
    idle(20);
    check_frames("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
